// File: rtl/ro_counter_bank.sv
// Ring-oscillator edge-counter bank: synchronises CH asynchronous oscillator inputs and
// counts rising edges over a programmable gate window, then holds the result for a
// valid/ready consumer.
module ro_counter_bank #(
   parameter int CH    = 4,
   parameter int CNT_W = 8,
   parameter int WIN_W = 16,
   parameter int SYNC  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIN_W-1:0]      window,
   input  logic [CH-1:0]         ro_in,
   output logic                  busy,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic [CH*CNT_W-1:0]   counts,
   output logic [CH-1:0]         overflow
);

   localparam int SET_W = $clog2(SYNC + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                   state_q;
   logic [SYNC-1:0][CH-1:0]  sync_q;
   logic [CH-1:0]            prev_q;
   logic [CH-1:0]            rise;
   logic [WIN_W-1:0]         window_q;
   logic [WIN_W-1:0]         win_cnt_q;
   logic [SET_W-1:0]         settle_q;
   logic [CH-1:0][CNT_W-1:0] cnt_q;
   logic [CH-1:0]            ovf_q;
   logic                     busy_q;
   logic                     done_valid_q;

   // Stage 0 captures the raw oscillator; the last stage is the metastability-safe copy.
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], ro_in};
         prev_q <= sync_q[SYNC-1];
      end
   end

   assign rise = sync_q[SYNC-1] & ~prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         window_q     <= '0;
         win_cnt_q    <= '0;
         settle_q     <= '0;
         cnt_q        <= '0;
         ovf_q        <= '0;
         busy_q       <= 1'b0;
         done_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q      <= SETTLE;
                  window_q     <= window;
                  settle_q     <= SET_W'(SYNC);
                  cnt_q        <= '0;
                  ovf_q        <= '0;
                  busy_q       <= 1'b1;
                  done_valid_q <= 1'b0;
               end
            end

            // Edges are ignored while the synchronisers flush pre-start history.
            SETTLE: begin
               if (settle_q == SET_W'(1)) begin
                  win_cnt_q <= window_q;
                  if (window_q == '0) begin
                     state_q      <= HOLD;
                     done_valid_q <= 1'b1;
                  end else begin
                     state_q <= COUNT;
                  end
               end else begin
                  settle_q <= settle_q - SET_W'(1);
               end
            end

            COUNT: begin
               for (int i = 0; i < CH; i++) begin
                  if (rise[i]) begin
                     if (&cnt_q[i]) begin
                        ovf_q[i] <= 1'b1;
                     end else begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                     end
                  end
               end
               if (win_cnt_q == WIN_W'(1)) begin
                  state_q      <= HOLD;
                  done_valid_q <= 1'b1;
               end else begin
                  win_cnt_q <= win_cnt_q - WIN_W'(1);
               end
            end

            HOLD: begin
               if (done_ready) begin
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  done_valid_q <= 1'b0;
               end
            end

            default: begin
               state_q      <= IDLE;
               busy_q       <= 1'b0;
               done_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done_valid = done_valid_q;
   assign counts     = cnt_q;
   assign overflow   = ovf_q;

endmodule
